// File: rtl/fp16_align_stage.sv
// FP16 add/sub operand alignment: order by magnitude, right-shift smaller significand with G/R/S.
// Latency: accept at T, out_valid at T + 2 + ceil(d/SHIFT_STEP); one pair in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, IDLE again next cycle.
module fp16_align_stage #(
  parameter int SHIFT_STEP = 1,
  parameter int MAX_SHIFT  = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  big_exp,
  output logic [10:0] big_mant,
  output logic [13:0] small_mant,
  output logic        res_sign,
  output logic        eff_sub,
  output logic        swapped,
  output logic        special,
  output logic        is_nan
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMP   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] C_STEP = 5'(SHIFT_STEP);
  localparam logic [4:0] C_MAX  = 5'(MAX_SHIFT);

  logic [1:0]  r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_op;
  logic [4:0]  r_rem;
  logic [4:0]  r_big_exp;
  logic [10:0] r_big_mant;
  logic [13:0] r_small_mant;
  logic        r_res_sign;
  logic        r_eff_sub;
  logic        r_swapped;
  logic        r_special;
  logic        r_is_nan;

  // Operand decode of the captured pair (used in COMPARE only).
  logic        w_a_sign, w_b_sign;
  logic        w_a_hid, w_b_hid;
  logic [4:0]  w_a_eexp, w_b_eexp;
  logic [14:0] w_a_key, w_b_key;
  logic        w_a_big;
  logic [4:0]  w_big_eexp, w_sml_eexp;
  logic [4:0]  w_diff, w_d;
  logic [10:0] w_big_mant;
  logic [13:0] w_sml_load;
  logic        w_a_max, w_b_max;
  logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_special, w_eff_sub, w_is_nan;
  logic        w_res_sign;

  assign w_a_sign = r_a[15];
  assign w_b_sign = r_b[15] ^ r_op;

  // Denormals (and zero) behave as exponent 1 with no hidden bit.
  assign w_a_hid  = |r_a[14:10];
  assign w_b_hid  = |r_b[14:10];
  assign w_a_eexp = w_a_hid ? r_a[14:10] : 5'd1;
  assign w_b_eexp = w_b_hid ? r_b[14:10] : 5'd1;

  // Ties favour A so that an exact match never reports a swap.
  assign w_a_key  = {w_a_eexp, r_a[9:0]};
  assign w_b_key  = {w_b_eexp, r_b[9:0]};
  assign w_a_big  = (w_a_key >= w_b_key);

  assign w_big_eexp = w_a_big ? w_a_eexp : w_b_eexp;
  assign w_sml_eexp = w_a_big ? w_b_eexp : w_a_eexp;
  assign w_diff     = w_big_eexp - w_sml_eexp;
  assign w_d        = (w_diff >= C_MAX) ? C_MAX : w_diff;

  assign w_big_mant = w_a_big ? {w_a_hid, r_a[9:0]} : {w_b_hid, r_b[9:0]};
  assign w_sml_load = w_a_big ? {w_b_hid, r_b[9:0], 3'b000} : {w_a_hid, r_a[9:0], 3'b000};

  assign w_a_max   = &r_a[14:10];
  assign w_b_max   = &r_b[14:10];
  assign w_a_inf   = w_a_max & ~(|r_a[9:0]);
  assign w_b_inf   = w_b_max & ~(|r_b[9:0]);
  assign w_a_nan   = w_a_max & (|r_a[9:0]);
  assign w_b_nan   = w_b_max & (|r_b[9:0]);
  assign w_special = w_a_max | w_b_max;
  assign w_eff_sub = w_a_sign ^ w_b_sign;
  assign w_is_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_eff_sub);

  // Result sign: NaN reports 0, an infinity dictates its own sign, exact cancellation is +0.
  always_comb begin
    w_res_sign = w_a_big ? w_a_sign : w_b_sign;
    if (w_is_nan) begin
      w_res_sign = 1'b0;
    end else if (w_a_inf) begin
      w_res_sign = w_a_sign;
    end else if (w_b_inf) begin
      w_res_sign = w_b_sign;
    end else if (w_eff_sub && (r_a[14:0] == r_b[14:0])) begin
      w_res_sign = 1'b0;
    end
  end

  // One alignment step: shift by min(step, remaining) and fold every lost bit into S.
  logic [4:0]  w_amt;
  logic [13:0] w_mask;
  logic        w_lost;
  logic [13:0] w_shifted;

  assign w_amt     = (r_rem > C_STEP) ? C_STEP : r_rem;
  assign w_mask    = (14'd1 << w_amt) - 14'd1;
  assign w_lost    = |(r_small_mant & w_mask);
  assign w_shifted = (r_small_mant >> w_amt) | {13'd0, w_lost};

  // Control FSM plus operand capture and aligned-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= 16'd0;
      r_b          <= 16'd0;
      r_op         <= 1'b0;
      r_rem        <= 5'd0;
      r_big_exp    <= 5'd0;
      r_big_mant   <= 11'd0;
      r_small_mant <= 14'd0;
      r_res_sign   <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_swapped    <= 1'b0;
      r_special    <= 1'b0;
      r_is_nan     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_big_exp    <= w_big_eexp;
          r_big_mant   <= w_big_mant;
          r_small_mant <= w_sml_load;
          r_res_sign   <= w_res_sign;
          r_eff_sub    <= w_eff_sub;
          r_swapped    <= ~w_a_big;
          r_special    <= w_special;
          r_is_nan     <= w_is_nan;
          r_rem        <= w_d;
          r_state      <= (w_special || (w_d == 5'd0)) ? S_DONE : S_SHIFT;
        end
        S_SHIFT: begin
          r_small_mant <= w_shifted;
          r_rem        <= r_rem - w_amt;
          if (r_rem == w_amt) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign big_exp    = r_big_exp;
  assign big_mant   = r_big_mant;
  assign small_mant = r_small_mant;
  assign res_sign   = r_res_sign;
  assign eff_sub    = r_eff_sub;
  assign swapped    = r_swapped;
  assign special    = r_special;
  assign is_nan     = r_is_nan;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Bench for fp16_align_stage: directed spec cases plus randomized pairs against an arithmetic model.
// Latency measured in rising edges after the accepting edge (out_valid at T+L -> L-1 edges).
// Exercises held results, early out_ready, ignored in_valid while busy and mid-shift reset.
module tb_fp16_align_stage;

  localparam int STEP = 1;
  localparam int MAXS = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  big_exp;
  logic [10:0] big_mant;
  logic [13:0] small_mant;
  logic        res_sign;
  logic        eff_sub;
  logic        swapped;
  logic        special;
  logic        is_nan;

  fp16_align_stage #(.SHIFT_STEP(STEP), .MAX_SHIFT(MAXS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_exp    (big_exp),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .res_sign   (res_sign),
    .eff_sub    (eff_sub),
    .swapped    (swapped),
    .special    (special),
    .is_nan     (is_nan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  typedef struct packed {
    logic [4:0]  big_exp;
    logic [10:0] big_mant;
    logic [13:0] small_mant;
    logic        res_sign;
    logic        eff_sub;
    logic        swapped;
    logic        special;
    logic        is_nan;
    logic [7:0]  lat;
  } exp_t;

  // Reference: value-level description of the alignment, no notion of cycles except the count.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic top);
    exp_t e;
    int ae, af, be, bf, aee, bee, akey, bkey, d, sig, shf;
    bit as_, bs_, abig, anan, bnan, ainf, binf, spec, nan;
    ae = int'(ta[14:10]);  af = int'(ta[9:0]);
    be = int'(tb_[14:10]); bf = int'(tb_[9:0]);
    as_ = ta[15];
    bs_ = tb_[15] ^ top;
    aee = (ae == 0) ? 1 : ae;
    bee = (be == 0) ? 1 : be;
    akey = aee * 1024 + af;
    bkey = bee * 1024 + bf;
    abig = (akey >= bkey);
    d = abig ? aee - bee : bee - aee;
    if (d > MAXS) d = MAXS;
    if (abig) sig = ((be != 0 ? 1024 : 0) + bf) * 8;
    else      sig = ((ae != 0 ? 1024 : 0) + af) * 8;
    shf = sig >> d;
    if ((sig % (1 << d)) != 0) shf = shf | 1;
    anan = (ae == 31) && (af != 0);
    bnan = (be == 31) && (bf != 0);
    ainf = (ae == 31) && (af == 0);
    binf = (be == 31) && (bf == 0);
    spec = (ae == 31) || (be == 31);
    nan  = anan || bnan || (ainf && binf && (as_ != bs_));
    e.big_exp    = 5'(abig ? aee : bee);
    e.big_mant   = abig ? 11'((ae != 0 ? 1024 : 0) + af) : 11'((be != 0 ? 1024 : 0) + bf);
    e.small_mant = 14'(shf);
    e.eff_sub    = as_ ^ bs_;
    e.swapped    = !abig;
    e.special    = spec;
    e.is_nan     = nan;
    if (nan)                                        e.res_sign = 1'b0;
    else if (ainf)                                  e.res_sign = as_;
    else if (binf)                                  e.res_sign = bs_;
    else if ((as_ != bs_) && (ta[14:0] == tb_[14:0])) e.res_sign = 1'b0;
    else                                            e.res_sign = abig ? as_ : bs_;
    e.lat = spec ? 8'd1 : 8'(1 + (d + STEP - 1) / STEP);
    return e;
  endfunction

  logic [4:0]  c_big_exp;
  logic [10:0] c_big_mant;
  logic [13:0] c_small_mant;
  logic        c_res_sign, c_eff_sub, c_swapped, c_special, c_is_nan;
  int          c_lat;

  // One transaction; entered and left at #1 after a rising edge.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic top,
                       input int hold, input bit rdy_early);
    exp_t e;
    int   cnt;
    bit   seen;
    e = model(ta, tb_, top);
    check("idle_in_ready", in_ready, 1);
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = rdy_early;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
    check("busy_in_ready", in_ready, 0);
    cnt = 0; seen = 0;
    while (!seen && cnt < 64) begin
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    c_lat = cnt;
    c_big_exp = big_exp; c_big_mant = big_mant; c_small_mant = small_mant;
    c_res_sign = res_sign; c_eff_sub = eff_sub; c_swapped = swapped;
    c_special = special; c_is_nan = is_nan;
    check("latency", cnt, e.lat);
    check("special", special, e.special);
    check("is_nan", is_nan, e.is_nan);
    check("eff_sub", eff_sub, e.eff_sub);
    if (!e.special) begin
      check("big_exp", big_exp, e.big_exp);
      check("big_mant", big_mant, e.big_mant);
      check("small_mant", small_mant, e.small_mant);
      check("swapped", swapped, e.swapped);
      check("res_sign", res_sign, e.res_sign);
    end else if (!e.is_nan) begin
      check("inf_sign", res_sign, e.res_sign);
    end
    if (hold > 0 && !rdy_early) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_small", small_mant, c_small_mant);
        check("hold_big", {big_exp, big_mant}, {c_big_exp, c_big_mant});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_outs"}, {big_exp, big_mant, small_mant, res_sign, eff_sub, swapped, special, is_nan}, 0);
  endtask

  logic [15:0] ra, rb;
  int          mode;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0; op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: equal operands, no shift
    do_op(16'h3C00, 16'h3C00, 1'b0, 0, 0);
    check("t1_lat", c_lat, 1);
    check("t1_big_exp", c_big_exp, 5'h0F);
    check("t1_big_mant", c_big_mant, 11'h400);
    check("t1_small", c_small_mant, 14'h2000);
    check("t1_sub_sign", {c_eff_sub, c_res_sign}, 2'b00);

    // T2: d=3
    do_op(16'h4800, 16'h3C00, 1'b1, 0, 0);
    check("t2_lat", c_lat, 4);
    check("t2_big_exp", c_big_exp, 5'h12);
    check("t2_small", c_small_mant, 14'h0400);
    check("t2_flags", {c_eff_sub, c_res_sign, c_swapped}, 3'b100);

    // T3: B larger after sign adjust
    do_op(16'h3C00, 16'h4000, 1'b1, 0, 0);
    check("t3_lat", c_lat, 2);
    check("t3_flags", {c_swapped, c_res_sign}, 2'b11);
    check("t3_big_mant", c_big_mant, 11'h400);
    check("t3_small", c_small_mant, 14'h1000);

    // T4: clamp to MAX_SHIFT, sticky only
    do_op(16'h7BFF, 16'h0001, 1'b0, 0, 0);
    check("t4_lat", c_lat, 15);
    check("t4_small", c_small_mant, 14'h0001);

    // T5: Inf - Inf and quiet NaN input
    do_op(16'h7C00, 16'h7C00, 1'b1, 0, 0);
    check("t5_lat", c_lat, 1);
    check("t5_flags", {c_special, c_is_nan}, 2'b11);
    do_op(16'h7E00, 16'h3C00, 1'b0, 0, 0);
    check("t5b_nan", c_is_nan, 1);

    // T6: hold result with out_ready low while in_valid pokes the busy stage
    do_op(16'h4800, 16'h3C00, 1'b1, 5, 0);

    // T6: reset in the middle of SHIFT
    a = 16'h7BFF; b = 16'h0001; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_shift_valid", out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (out_valid) check("abandoned_valid", out_valid, 0);
    end
    check("after_rst_ready", in_ready, 1);
    do_op(16'h4000, 16'hBC00, 1'b0, 0, 1);

    // Randomized pairs, biased toward close exponents, denormals, specials and equal magnitudes
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb[14:10] = 5'((int'(ra[14:10]) + $urandom_range(0, 4)) % 31);
        1: begin ra[14:10] = 5'd0; rb[14:10] = 5'($urandom_range(0, 2)); end
        2: rb[14:10] = 5'd31;
        3: rb[14:0] = ra[14:0];
        4: begin ra[14:10] = 5'd31; rb[14:10] = 5'd31; rb[9:0] = 10'($urandom_range(0, 1)); ra[9:0] = 10'd0; end
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), ($urandom_range(0, 5) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
